// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline write-enable/flush sequencing for the five-stage
//                MIPS core (memory freeze, branch flush, MDU occupancy, load-use).
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MDU_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_uses_rt,
    input  logic        ID_EX_mem_read,
    input  logic [4:0]  ID_EX_rt,
    input  logic        mdu_start,
    input  logic        EX_MEM_PCSrc,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        IF_ID_write,
    output logic        ID_EX_write,
    output logic        EX_MEM_write,
    output logic        MEM_WB_write,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        EX_MEM_flush,
    output logic        mdu_busy,
    output logic [15:0] stall_cycles
);

    localparam logic       c_RUN      = 1'b0;
    localparam logic       c_MDU      = 1'b1;
    localparam logic [3:0] c_MDU_LOAD = 4'(MDU_LATENCY - 1);
    localparam logic       c_MDU_EN   = (MDU_LATENCY > 1);

    logic        r_state;
    logic [3:0]  r_mdu_cnt;
    logic [15:0] r_stall_cycles;

    logic        w_load_use;
    logic        w_mdu_enter;
    logic [3:0]  w_cnt_dec;

    assign w_load_use  = ID_EX_mem_read && (ID_EX_rt != 5'd0) &&
                         ((ID_EX_rt == ID_rs) || (ID_uses_rt && (ID_EX_rt == ID_rt)));
    assign w_mdu_enter = (r_state == c_RUN) && mdu_start && c_MDU_EN;
    assign w_cnt_dec   = r_mdu_cnt - 4'd1;

    always_comb begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_write  = 1'b1;
        EX_MEM_write = 1'b1;
        MEM_WB_write = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        if (rst) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
        end else if (mem_busy) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_write = 1'b0;
        end else if (EX_MEM_PCSrc) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
        end else if (r_state == c_MDU) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_flush = 1'b1;
        end else if (w_load_use) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_flush  = 1'b1;
        end else if (w_mdu_enter) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_flush = 1'b1;
        end
    end

    assign mdu_busy     = !rst && (r_state == c_MDU);
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_RUN;
            r_mdu_cnt      <= 4'd0;
            r_stall_cycles <= 16'd0;
        end else begin
            if (!pc_write && (r_stall_cycles != 16'hFFFF))
                r_stall_cycles <= r_stall_cycles + 16'd1;
            if (!mem_busy) begin
                if (EX_MEM_PCSrc) begin
                    r_state   <= c_RUN;
                    r_mdu_cnt <= 4'd0;
                end else if (r_state == c_MDU) begin
                    // Leave one cycle early so the op's last EX cycle runs unstalled.
                    if (w_cnt_dec <= 4'd1) begin
                        r_state   <= c_RUN;
                        r_mdu_cnt <= 4'd0;
                    end else begin
                        r_mdu_cnt <= w_cnt_dec;
                    end
                end else if (!w_load_use && w_mdu_enter) begin
                    r_state   <= c_MDU;
                    r_mdu_cnt <= c_MDU_LOAD;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Vector-table bench with an expected-value queue for hazard_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_rs, ID_rt, ID_EX_rt;
    logic        ID_uses_rt, ID_EX_mem_read, mdu_start, EX_MEM_PCSrc, mem_busy;
    logic        pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
    logic        IF_ID_flush, ID_EX_flush, EX_MEM_flush, mdu_busy;
    logic [15:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_ctrl #(.MDU_LATENCY(4)) dut (
        .clk(clk), .rst(rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
        .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_rt(ID_EX_rt),
        .mdu_start(mdu_start), .EX_MEM_PCSrc(EX_MEM_PCSrc), .mem_busy(mem_busy),
        .pc_write(pc_write), .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write),
        .EX_MEM_write(EX_MEM_write), .MEM_WB_write(MEM_WB_write),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush),
        .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
    );

    // Expected bundle: {pc, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, exmem_f, mdu_busy}
    localparam logic [8:0] E_RST  = 9'b11111_111_0;
    localparam logic [8:0] E_RUN  = 9'b11111_000_0;
    localparam logic [8:0] E_LU   = 9'b00111_010_0;
    localparam logic [8:0] E_MST  = 9'b00011_001_0;
    localparam logic [8:0] E_MDU  = 9'b00011_001_1;
    localparam logic [8:0] E_BR   = 9'b11111_111_0;
    localparam logic [8:0] E_BRM  = 9'b11111_111_1;
    localparam logic [8:0] E_FRZ  = 9'b00000_000_0;
    localparam logic [8:0] E_FRZM = 9'b00000_000_1;

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt;
        logic       uses_rt, mr;
        logic [4:0] exrt;
        logic       start, pcsrc, busy;
        logic [8:0] exp;
        string      name;
    } vec_t;

    typedef struct {
        logic [8:0] exp;
        string      name;
    } sb_t;

    vec_t  vecs[$];
    sb_t   sbq[$];
    int    errors = 0;
    int    checks = 0;
    int    exp_stall = 0;

    function automatic vec_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                input logic ur, input logic mr, input logic [4:0] exrt,
                                input logic st, input logic br, input logic bz,
                                input logic [8:0] e, input string n);
        vec_t v;
        v.rst = r; v.rs = rs; v.rt = rt; v.uses_rt = ur; v.mr = mr; v.exrt = exrt;
        v.start = st; v.pcsrc = br; v.busy = bz; v.exp = e; v.name = n;
        return v;
    endfunction

    function automatic logic [8:0] observed();
        return {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
                IF_ID_flush, ID_EX_flush, EX_MEM_flush, mdu_busy};
    endfunction

    task automatic check_stall(input string n);
        checks++;
        if (stall_cycles != 16'(exp_stall)) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", n, stall_cycles, exp_stall);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rt = 1'b0; ID_EX_mem_read = 1'b0;
        ID_EX_rt = 5'd0; mdu_start = 1'b0; EX_MEM_PCSrc = 1'b0; mem_busy = 1'b0;
    endtask

    initial begin
        sb_t s;
        idle_inputs();
        rst = 1'b1;

        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RST, "reset0"));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RST, "reset1"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, "post_reset"));
        vecs.push_back(mk(0, 5, 0, 0, 1, 5, 0, 0, 0, E_LU,  "lu_rs"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, "after_lu"));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, E_RUN, "lu_rt_zero"));
        vecs.push_back(mk(0, 3, 5, 0, 1, 5, 0, 0, 0, E_RUN, "lu_rt_unused"));
        vecs.push_back(mk(0, 3, 5, 1, 1, 5, 0, 0, 0, E_LU,  "lu_rt_used"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, E_MST, "mdu_c1"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_MDU, "mdu_c2"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_MDU, "mdu_c3"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, "mdu_final"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, E_MST, "bm_c1"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_MDU, "bm_c2"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_BRM, "bm_branch"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, "bm_after"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, E_FRZ, "frz_br1"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, E_FRZ, "frz_br2"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, E_FRZ, "frz_br3"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_BR,  "frz_br_release"));
        vecs.push_back(mk(0, 7, 0, 0, 1, 7, 0, 1, 0, E_BR,  "br_over_lu"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, E_FRZ, "start_in_freeze"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, "start_dropped"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, E_MST, "fm_c1"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_FRZM,"fm_freeze"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_MDU, "fm_c2"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, E_MDU, "fm_c3_restart"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, "fm_final"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, E_MST, "rm_c1"));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RST, "rm_reset"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, "rm_after"));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            rst = vecs[i].rst; ID_rs = vecs[i].rs; ID_rt = vecs[i].rt;
            ID_uses_rt = vecs[i].uses_rt; ID_EX_mem_read = vecs[i].mr;
            ID_EX_rt = vecs[i].exrt; mdu_start = vecs[i].start;
            EX_MEM_PCSrc = vecs[i].pcsrc; mem_busy = vecs[i].busy;
            s.exp = vecs[i].exp; s.name = vecs[i].name;
            sbq.push_back(s);
            @(negedge clk);
            s = sbq.pop_front();
            checks++;
            if (observed() !== s.exp) begin
                errors++;
                $display("FAIL %s outputs: got %b expected %b", s.name, observed(), s.exp);
            end
            if (!vecs[i].rst) check_stall(s.name);
            // Counter effect of this cycle becomes visible after the coming edge.
            if (vecs[i].rst) exp_stall = 0;
            else if (!s.exp[8]) exp_stall++;
        end

        // Saturation: long memory stall drives the counter to its ceiling.
        @(posedge clk); #1;
        idle_inputs();
        mem_busy = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        exp_stall = 65535;
        check_stall("sat_reached");
        checks++;
        if (pc_write !== 1'b0) begin
            errors++;
            $display("FAIL sat_pc_write: got %b expected 0", pc_write);
        end
        repeat (5) @(posedge clk);
        #1;
        check_stall("sat_hold");
        mem_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_stall("sat_after_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
